// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D memory-port arbiter.
package mem_arb_pkg;

  localparam int MAX_WAIT_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter. slave = arbiter view,
// master = the surrounding datapath/memory view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic              i_err;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [3:0]        d_wmask;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [3:0]        m_wmask;
  logic              m_gnt;
  logic              m_rvalid;
  logic [DATA_W-1:0] m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wmask,
    input  m_gnt, m_rvalid, m_rdata,
    output i_gnt, i_rvalid, i_rdata, i_err,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output m_req, m_we, m_addr, m_wdata, m_wmask
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wmask,
    output m_gnt, m_rvalid, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, i_err,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  m_req, m_we, m_addr, m_wdata, m_wmask
  );
endinterface

// File: rtl/mem_arb_select.sv
// Winner selection between fetch and load/store requests.
// MEM_ARB_RR_EN: round-robin on ties; otherwise D always wins a tie.
module mem_arb_select
  import mem_arb_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  arb_owner_t last_owner,
  output logic       any_req,
  output arb_owner_t winner
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    any_req = i_req | d_req;
    winner  = OWN_D;
    if (i_req && d_req) begin
      winner = (last_owner == OWN_I) ? OWN_D : OWN_I;
    end else if (i_req) begin
      winner = OWN_I;
    end
  end
`else
  // Fixed priority has no use for history; keep the port for a uniform interface.
  logic unused_last_owner;
  assign unused_last_owner = last_owner;

  always_comb begin
    any_req = i_req | d_req;
    winner  = (i_req && !d_req) ? OWN_I : OWN_D;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch (I) and load/store (D), one transaction
// at a time. Build option MEM_ARB_RR_EN enables round-robin tie-breaking.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int               CNT_W    = $clog2(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [3:0]        m_wmask_q, m_wmask_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic       any_req;
  arb_owner_t winner;
  logic       grant_ok;
  logic       i_resp;
  logic       d_resp;

  mem_arb_select u_select (
    .i_req      (bus.i_req),
    .d_req      (bus.d_req),
    .last_owner (owner_q),
    .any_req    (any_req),
    .winner     (winner)
  );

  // Grants are gated by reset so every output reads 0 while rst is low.
  assign grant_ok = rst && (state_q == IDLE) && any_req;

  always_comb begin
    // NOTE: every _d gets its hold value first, so no branch can infer a latch.
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_wmask_d = m_wmask_q;
    rdata_d   = rdata_q;
    err_d     = err_q;

    unique case (state_q)
      IDLE: begin
        if (grant_ok) begin
          state_d = REQ;
          owner_d = winner;
          m_req_d = 1'b1;
          if (winner == OWN_I) begin
            m_we_d    = 1'b0;
            m_addr_d  = bus.i_addr;
            m_wdata_d = '0;
            m_wmask_d = 4'hF;
          end else begin
            m_we_d    = bus.d_we;
            m_addr_d  = bus.d_addr;
            m_wdata_d = bus.d_wdata;
            m_wmask_d = bus.d_wmask;
          end
        end
      end
      REQ: begin
        if (bus.m_gnt) begin
          state_d = WAIT;
          m_req_d = 1'b0;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        // A response in the timeout cycle still wins.
        if (bus.m_rvalid) begin
          rdata_d = bus.m_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: non-blocking assignments make every register sample pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_D;
      cnt_q     <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wmask_q <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wmask_q <= m_wmask_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign i_resp = (state_q == RESP) && (owner_q == OWN_I);
  assign d_resp = (state_q == RESP) && (owner_q == OWN_D);

  assign bus.i_gnt    = grant_ok && (winner == OWN_I);
  assign bus.i_rvalid = i_resp;
  assign bus.i_rdata  = i_resp ? rdata_q : '0;
  assign bus.i_err    = i_resp & err_q;

  assign bus.d_gnt    = grant_ok && (winner == OWN_D);
  assign bus.d_rvalid = d_resp;
  assign bus.d_rdata  = d_resp ? rdata_q : '0;
  assign bus.d_err    = d_resp & err_q;

  assign bus.m_req    = m_req_q;
  assign bus.m_we     = m_we_q;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_wdata  = m_wdata_q;
  assign bus.m_wmask  = m_wmask_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: responses expected at grant time are
// queued and matched against I/D responses by a monitor.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 16;

  typedef struct packed {
    logic          side_d;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  // Memory model controls
  int            gnt_stall = 0;
  int            rsp_stall = 0;
  bit            manual    = 1'b0;
  logic          man_rvalid = 1'b0;
  logic [DW-1:0] man_rdata  = '0;
  int            gcnt = 0;
  int            rcnt = 0;
  bit            pend = 1'b0;
  logic [AW-1:0] lat_addr = '0;
  logic          lat_we = 1'b0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return (a == 32'h8000_0000) ? 32'h0010_0073 : (a ^ 32'h1357_9BDF);
  endfunction

  function automatic logic any_out();
    return |{bus.i_gnt, bus.i_rvalid, bus.i_rdata, bus.i_err,
             bus.d_gnt, bus.d_rvalid, bus.d_rdata, bus.d_err,
             bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata, bus.m_wmask};
  endfunction

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rvalid(input int start, input int budget, output int at);
    at = -1;
    for (int c = start; c < start + budget; c++) begin
      cyc();
      @(negedge clk);
      if (bus.i_rvalid === 1'b1 || bus.d_rvalid === 1'b1) begin
        at = c;
        break;
      end
    end
  endtask

  // Memory responder: grants after gnt_stall cycles of m_req, answers
  // rsp_stall cycles later (never if negative). Write acks return 0.
  initial begin
    bus.m_gnt = 1'b0; bus.m_rvalid = 1'b0; bus.m_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (manual) begin
        bus.m_gnt = 1'b0; bus.m_rvalid = man_rvalid; bus.m_rdata = man_rdata;
        pend = 1'b0; gcnt = 0;
      end else begin
        bus.m_gnt = 1'b0; bus.m_rvalid = 1'b0; bus.m_rdata = '0;
        if (!rst) begin
          gcnt = 0; pend = 1'b0;
        end else if (bus.m_req) begin
          if (gcnt >= gnt_stall) begin
            bus.m_gnt = 1'b1; gcnt = 0; pend = 1'b1; rcnt = 0;
            lat_addr = bus.m_addr; lat_we = bus.m_we;
          end else begin
            gcnt++;
          end
        end else if (pend) begin
          if (rsp_stall >= 0 && rcnt >= rsp_stall) begin
            bus.m_rvalid = 1'b1;
            bus.m_rdata  = lat_we ? '0 : mem_word(lat_addr);
            pend = 1'b0;
          end else begin
            rcnt++;
          end
        end
      end
    end
  end

  // Response monitor / scoreboard
  initial begin
    exp_t e, got;
    forever begin
      @(negedge clk);
      if (bus.i_rvalid === 1'b1 || bus.d_rvalid === 1'b1) begin
        n_tests++;
        if (bus.i_rvalid === 1'b1 && bus.d_rvalid === 1'b1) begin
          n_fail++;
          $display("FAIL resp_onehot: got i_rvalid=1 d_rvalid=1, want only one");
        end else if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL resp_unexpected: got i_rvalid=%b d_rvalid=%b, want none",
                   bus.i_rvalid, bus.d_rvalid);
        end else begin
          e = sb.pop_front();
          got.side_d = bus.d_rvalid;
          got.rdata  = bus.d_rvalid ? bus.d_rdata : bus.i_rdata;
          got.err    = bus.d_rvalid ? bus.d_err : bus.i_err;
          if (got !== e) begin
            n_fail++;
            $display("FAIL resp_data: got side_d=%b rdata=%h err=%b, want side_d=%b rdata=%h err=%b",
                     got.side_d, got.rdata, got.err, e.side_d, e.rdata, e.err);
          end
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0;
    bus.d_wdata = '0; bus.d_wmask = 4'h0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (3) cyc();
    @(negedge clk);
    n_tests++;
    if (any_out() !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got any_out=%b, want 0", any_out());
    end
    cyc();
    rst = 1'b1;
  endtask

  task automatic test_read_i();
    int at;
    gnt_stall = 0; rsp_stall = 0;
    cyc();
    bus.i_req = 1'b1; bus.i_addr = 32'h8000_0000;
    @(negedge clk);
    n_tests++;
    if ({bus.i_gnt, bus.d_gnt} !== 2'b10) begin
      n_fail++;
      $display("FAIL read_i_gnt: got i_gnt=%b d_gnt=%b, want 1 0", bus.i_gnt, bus.d_gnt);
    end
    sb.push_back('{1'b0, 32'h0010_0073, 1'b0});
    cyc();
    bus.i_req = 1'b0; bus.i_addr = 32'hFFFF_FFFC;
    @(negedge clk);
    n_tests++;
    if ({bus.m_req, bus.m_we, bus.m_addr, bus.m_wmask} !== {1'b1, 1'b0, 32'h8000_0000, 4'hF}) begin
      n_fail++;
      $display("FAIL read_i_mreq: got req=%b we=%b addr=%h mask=%h, want 1 0 80000000 f",
               bus.m_req, bus.m_we, bus.m_addr, bus.m_wmask);
    end
    wait_rvalid(2, 10, at);
    n_tests++;
    if (at !== 3) begin
      n_fail++;
      $display("FAIL read_i_latency: got cycle %0d, want 3", at);
    end
  endtask

  task automatic test_write_d();
    int at;
    gnt_stall = 2; rsp_stall = 0;
    cyc();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h8000_1000;
    bus.d_wdata = 32'hDEAD_BEEF; bus.d_wmask = 4'h3;
    @(negedge clk);
    n_tests++;
    if ({bus.i_gnt, bus.d_gnt} !== 2'b01) begin
      n_fail++;
      $display("FAIL write_d_gnt: got i_gnt=%b d_gnt=%b, want 0 1", bus.i_gnt, bus.d_gnt);
    end
    sb.push_back('{1'b1, 32'h0, 1'b0});
    cyc();
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h1234_5678;
    bus.d_wdata = 32'h0; bus.d_wmask = 4'hC;
    @(negedge clk);
    n_tests++;
    if ({bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata, bus.m_wmask} !==
        {1'b1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'h3}) begin
      n_fail++;
      $display("FAIL write_d_mreq: got req=%b we=%b addr=%h wdata=%h mask=%h, want 1 1 80001000 deadbeef 3",
               bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata, bus.m_wmask);
    end
    cyc();
    @(negedge clk);
    n_tests++;
    if ({bus.m_req, bus.m_addr, bus.m_wdata} !== {1'b1, 32'h8000_1000, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL write_d_hold: got req=%b addr=%h wdata=%h, want 1 80001000 deadbeef",
               bus.m_req, bus.m_addr, bus.m_wdata);
    end
    wait_rvalid(3, 10, at);
    n_tests++;
    if (at !== 5) begin
      n_fail++;
      $display("FAIL write_d_latency: got cycle %0d, want 5", at);
    end
  endtask

  task automatic test_arbitration();
    logic exp_d[3];
    logic side_d;
    int   last_c, n, at;
`ifdef MEM_ARB_RR_EN
    exp_d = '{1'b0, 1'b1, 1'b0};
`else
    exp_d = '{1'b1, 1'b1, 1'b1};
`endif
    gnt_stall = 0; rsp_stall = 0;
    last_c = 0; n = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      cyc();
      if (c == 0) begin
        bus.i_req = 1'b1; bus.i_addr = 32'h8000_0040;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h8000_0880;
        bus.d_wmask = 4'hF;
      end
      @(negedge clk);
      if (bus.i_gnt === 1'b1 || bus.d_gnt === 1'b1) begin
        side_d = bus.d_gnt;
        n_tests++;
        if ((bus.i_gnt === 1'b1 && bus.d_gnt === 1'b1) || side_d !== exp_d[n]) begin
          n_fail++;
          $display("FAIL arb_winner%0d: got i_gnt=%b d_gnt=%b, want d_gnt=%b",
                   n, bus.i_gnt, bus.d_gnt, exp_d[n]);
        end
        sb.push_back('{side_d, mem_word(side_d ? 32'h8000_0880 : 32'h8000_0040), 1'b0});
        if (n > 0) begin
          n_tests++;
          if (c - last_c !== 4) begin
            n_fail++;
            $display("FAIL arb_spacing%0d: got %0d cycles, want 4", n, c - last_c);
          end
        end
        last_c = c;
        n++;
      end
    end
    cyc();
    idle_inputs();
    n_tests++;
    if (n !== 3) begin
      n_fail++;
      $display("FAIL arb_grants: got %0d grants, want 3", n);
    end
    wait_rvalid(0, 10, at);
    n_tests++;
    if (at < 0) begin
      n_fail++;
      $display("FAIL arb_drain: got no final response, want one");
    end
  endtask

  // Timeout, optionally with the response landing in the timeout cycle itself.
  task automatic test_timeout(input bit race);
    int at;
    logic [AW-1:0] a;
    a = race ? 32'h8000_2000 : 32'h8000_3000;
    gnt_stall = 0; rsp_stall = race ? MW - 1 : -1;
    cyc();
    if (race) begin bus.i_req = 1'b1; bus.i_addr = a; end
    else begin bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = a; bus.d_wmask = 4'hF; end
    @(negedge clk);
    sb.push_back(race ? '{1'b0, mem_word(a), 1'b0} : '{1'b1, 32'h0, 1'b1});
    cyc();
    idle_inputs();
    @(negedge clk);
    n_tests++;
    if (bus.m_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_mgnt: got m_gnt=%b, want 1", bus.m_gnt);
    end
    wait_rvalid(2, 40, at);
    n_tests++;
    if (at - 1 !== MW + 1) begin
      n_fail++;
      $display("FAIL timeout_latency(race=%0d): got %0d cycles after m_gnt, want %0d",
               race, at - 1, MW + 1);
    end
  endtask

  task automatic test_late_rvalid();
    bit seen;
    cyc();
    man_rvalid = 1'b1; man_rdata = 32'hBAD0_BAD0; manual = 1'b1;
    cyc();
    man_rvalid = 1'b0; man_rdata = '0;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.i_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0 || bus.m_req !== 1'b0) seen = 1'b1;
      cyc();
    end
    manual = 1'b0;
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL late_rvalid: got activity after stale m_rvalid, want none");
    end
  endtask

  task automatic test_reset_mid();
    int at;
    gnt_stall = 0; rsp_stall = -1;
    cyc();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h8000_4000;
    bus.d_wdata = 32'hCAFE_F00D; bus.d_wmask = 4'hF;
    cyc();
    idle_inputs();
    repeat (2) cyc();
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_tests++;
    if (any_out() !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got any_out=%b, want 0", any_out());
    end
    rsp_stall = 0;
    repeat (2) cyc();
    cyc();
    rst = 1'b1;
    bus.i_req = 1'b1; bus.i_addr = 32'h8000_5000;
    @(negedge clk);
    n_tests++;
    if ({bus.i_gnt, bus.d_gnt} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_regrant: got i_gnt=%b d_gnt=%b, want 1 0", bus.i_gnt, bus.d_gnt);
    end
    sb.push_back('{1'b0, mem_word(32'h8000_5000), 1'b0});
    cyc();
    idle_inputs();
    wait_rvalid(2, 10, at);
    n_tests++;
    if (at !== 3) begin
      n_fail++;
      $display("FAIL reset_regrant_latency: got cycle %0d, want 3", at);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_read_i();
    test_write_d();
    test_arbitration();
    test_timeout(1'b0);
    test_late_rvalid();
    test_timeout(1'b1);
    test_reset_mid();
    repeat (3) cyc();
    n_tests++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %0d pending, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
